// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg: shared widths, RV32I opcode/funct constants and ALU
// operation codes used by the decode/issue stage and its helpers.
package decode_issue_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int OPCODE_WIDTH   = 7;
    localparam int FUNCT3_WIDTH   = 3;
    localparam int FUNCT7_WIDTH   = 7;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [OPCODE_WIDTH-1:0] OP     = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OP_IMM = 7'b0010011;

    localparam logic [FUNCT7_WIDTH-1:0] F7_BASE = 7'b0000000;
    localparam logic [FUNCT7_WIDTH-1:0] F7_ALT  = 7'b0100000;

    // ALU operation codes (funct3 encoding)
    typedef enum logic [FUNCT3_WIDTH-1:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

    function automatic logic is_shift(input logic [FUNCT3_WIDTH-1:0] f3);
        return (f3 == ALU_SLL) || (f3 == ALU_SR);
    endfunction

endpackage

// File: rtl/decode_issue_imm_gen.sv
// imm_gen: combinational immediate extraction for OP-IMM.
//   imm12 : instruction bits [31:20]
//   f3    : instruction bits [14:12]
//   imm   : zero-extended shamt for shifts, sign-extended imm12 otherwise
module imm_gen
    import decode_issue_pkg::*;
(
    input  logic [11:0]              imm12,
    input  logic [FUNCT3_WIDTH-1:0]  f3,
    output logic [DATA_WIDTH-1:0]    imm
);

    always_comb begin
        if (is_shift(f3)) begin
            imm = {{(DATA_WIDTH-5){1'b0}}, imm12[4:0]};
        end else begin
            imm = {{(DATA_WIDTH-12){imm12[11]}}, imm12};
        end
    end

endmodule

// File: rtl/decode_issue.sv
// decode_issue: RV32I OP/OP-IMM decode and issue stage.
//   in_valid/in_ready/in_instr : instruction input handshake
//   rs1_addr/rs2_addr          : register-file read addresses (combinational)
//   rs1_data/rs2_data          : register-file read data (same cycle)
//   out_valid/out_ready        : issue handshake to the ALU
//   s1,s2,opcode,f3,f7,rd      : registered issued operation
//   wb_valid/wb_rd             : writeback retire, clears the busy bit
//   flush                      : drop the held, not-yet-consumed operation
//   illegal                    : one-cycle pulse for a consumed illegal instruction
module decode_issue
    import decode_issue_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_instr,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic [DATA_WIDTH-1:0]     rs1_data,
    input  logic [DATA_WIDTH-1:0]     rs2_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     s1,
    output logic [DATA_WIDTH-1:0]     s2,
    output logic [OPCODE_WIDTH-1:0]   opcode,
    output logic [FUNCT3_WIDTH-1:0]   f3,
    output logic [FUNCT7_WIDTH-1:0]   f7,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic                      flush,
    output logic                      illegal
);

    logic [OPCODE_WIDTH-1:0]   dec_opcode;
    logic [FUNCT3_WIDTH-1:0]   dec_f3;
    logic [FUNCT7_WIDTH-1:0]   raw_f7;
    logic [FUNCT7_WIDTH-1:0]   dec_f7;
    logic [REG_ADDR_WIDTH-1:0] dec_rd;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     dec_s2;
    logic                      is_op;
    logic                      is_opimm;
    logic                      legal;
    logic                      hazard;
    logic                      accept;
    logic                      load;
    logic [31:0]               busy;
    logic [31:0]               busy_nxt;

    assign dec_opcode = in_instr[6:0];
    assign dec_rd     = in_instr[11:7];
    assign dec_f3     = in_instr[14:12];
    assign rs1_addr   = in_instr[19:15];
    assign rs2_addr   = in_instr[24:20];
    assign raw_f7     = in_instr[31:25];

    imm_gen u_imm_gen (
        .imm12 (in_instr[31:20]),
        .f3    (dec_f3),
        .imm   (imm)
    );

    always_comb begin
        is_op    = (dec_opcode == OP);
        is_opimm = (dec_opcode == OP_IMM);
        legal    = 1'b0;
        dec_s2   = rs2_data;
        dec_f7   = raw_f7;
        if (is_op) begin
            // Alternate funct7 only encodes SUB and SRA
            legal = (raw_f7 == F7_BASE) ||
                    ((raw_f7 == F7_ALT) && ((dec_f3 == ALU_ADD) || (dec_f3 == ALU_SR)));
        end else if (is_opimm) begin
            dec_s2 = imm;
            if (dec_f3 == ALU_SLL) begin
                legal = (raw_f7 == F7_BASE);
            end else if (dec_f3 == ALU_SR) begin
                legal = (raw_f7 == F7_BASE) || (raw_f7 == F7_ALT);
            end else begin
                // Upper immediate bits are not a funct7 here
                legal  = 1'b1;
                dec_f7 = F7_BASE;
            end
        end
    end

    // rs2 field is immediate data for OP-IMM, so it only counts for OP
    assign hazard   = legal & (busy[rs1_addr] | (is_op & busy[rs2_addr]) | busy[dec_rd]);
    assign in_ready = (!out_valid | out_ready) & !hazard & !flush;
    assign accept   = in_valid & in_ready;
    assign load     = accept & legal;

    always_comb begin
        busy_nxt = busy;
        if (wb_valid) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (flush && out_valid) begin
            busy_nxt[rd] = 1'b0;
        end
        if (load && (dec_rd != '0)) begin
            busy_nxt[dec_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Issue register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            busy      <= '0;
            s1        <= '0;
            s2        <= '0;
            opcode    <= '0;
            f3        <= '0;
            f7        <= '0;
            rd        <= '0;
        end else begin
            busy    <= busy_nxt;
            illegal <= accept & !legal;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (load) begin
                s1     <= rs1_data;
                s2     <= dec_s2;
                opcode <= dec_opcode;
                f3     <= dec_f3;
                f7     <= dec_f7;
                rd     <= dec_rd;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
module tb_decode_issue;

    typedef struct packed {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s1, s2;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        illegal;

    logic [31:0] rf [32];
    exp_t        q [$];
    int          checks   = 0;
    int          failures = 0;
    int          ill_cnt  = 0;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    always #5 clk = ~clk;

    decode_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s1        (s1),
        .s2        (s2),
        .opcode    (opcode),
        .f3        (f3),
        .f7        (f7),
        .rd        (rd),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .illegal   (illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [6:0] o,
                                input logic [2:0] f3v, input logic [6:0] f7v, input logic [4:0] r);
        exp_t e;
        e.s1 = a; e.s2 = b; e.opc = o; e.f3 = f3v; e.f7 = f7v; e.rd = r;
        return e;
    endfunction

    // Monitor: compare every consumed operation against the scoreboard
    always @(negedge clk) begin
        if (rst_n && illegal) ill_cnt++;
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            exp_t a;
            checks++;
            a = mk(s1, s2, opcode, f3, f7, rd);
            if (q.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected: got s1=%08h s2=%08h rd=%0d expected no issue", s1, s2, rd);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL issue: got s1=%08h s2=%08h op=%02h f3=%0d f7=%02h rd=%0d expected s1=%08h s2=%08h op=%02h f3=%0d f7=%02h rd=%0d",
                             a.s1, a.s2, a.opc, a.f3, a.f7, a.rd, e.s1, e.s2, e.opc, e.f3, e.f7, e.rd);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ins);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_instr = ins;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 20) begin
                chk("accept_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r);
        @(posedge clk); #1;
        wb_valid = 1'b1;
        wb_rd    = r;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h100;
        rf[0] = 32'd0; rf[1] = 32'd5; rf[2] = 32'd7; rf[3] = 32'h30;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_busy", dut.busy, 32'd0);
        chk("rst_s1", s1, 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD x3,x1,x2
        q.push_back(mk(32'd5, 32'd7, 7'h33, 3'd0, 7'h00, 5'd3));
        issue(32'h002081B3);
        @(negedge clk);
        chk("add_busy3", 32'(dut.busy[3]), 32'd1);
        wb(5'd3);
        @(negedge clk);
        chk("wb_clear3", 32'(dut.busy[3]), 32'd0);

        // ADDI x4,x0,-1
        q.push_back(mk(32'd0, 32'hFFFFFFFF, 7'h13, 3'd0, 7'h00, 5'd4));
        issue(32'hFFF00213);
        wb(5'd4);

        // SLTI x7,x1,-2048: upper immediate bits must not leak into f7
        q.push_back(mk(32'd5, 32'hFFFFF800, 7'h13, 3'd2, 7'h00, 5'd7));
        issue(32'h8000A393);
        wb(5'd7);

        // ADDI x0,x0,0 must not mark x0 busy
        q.push_back(mk(32'd0, 32'd0, 7'h13, 3'd0, 7'h00, 5'd0));
        issue(32'h00000013);
        @(negedge clk);
        chk("x0_not_busy", dut.busy, 32'd0);

        // RAW stall: ADD x3 then SUB x5,x3,x1
        q.push_back(mk(32'd5, 32'd7, 7'h33, 3'd0, 7'h00, 5'd3));
        issue(32'h002081B3);
        q.push_back(mk(32'h30, 32'd5, 7'h33, 3'd0, 7'h20, 5'd5));
        in_valid = 1'b1;
        in_instr = 32'h401182B3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("raw_stall", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_rd = 5'd3;
        @(negedge clk);
        chk("raw_no_bypass", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        chk("raw_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wb(5'd5);

        // SRAI x6,x1,4 then illegal SLLI x6 with alternate f7
        q.push_back(mk(32'd5, 32'd4, 7'h13, 3'd5, 7'h20, 5'd6));
        issue(32'h4040D313);
        issue(32'h40409313);
        @(negedge clk);
        chk("slli_illegal_pulse", 32'(illegal), 32'd1);
        chk("slli_no_valid", 32'(out_valid), 32'd0);
        chk("slli_busy6_kept", 32'(dut.busy[6]), 32'd1);
        @(negedge clk);
        chk("slli_pulse_end", 32'(illegal), 32'd0);
        wb(5'd6);
        issue(32'h022081B3);   // OP with bad funct7
        issue(32'h4020C1B3);   // XOR with alternate funct7
        issue(32'h0000A183);   // LW: unsupported opcode
        @(negedge clk);
        chk("illegal_no_busy", dut.busy, 32'd0);

        // Backpressure then flush
        out_ready = 1'b0;
        issue(32'h002081B3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_s1", s1, 32'd5);
            chk("bp_rd", 32'(rd), 32'd3);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_blocks", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        q.push_back(mk(32'd0, 32'hFFFFFFFF, 7'h13, 3'd0, 7'h00, 5'd4));
        in_valid = 1'b1;
        in_instr = 32'hFFF00213;
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_busy3", 32'(dut.busy[3]), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_issue", 32'(out_valid), 32'd1);
        wb(5'd4);

        // Asynchronous reset during backpressure
        out_ready = 1'b0;
        issue(32'h002081B3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", dut.busy, 32'd0);
        chk("arst_s1", s1, 32'd0);
        chk("arst_s2", s2, 32'd0);
        chk("arst_op", {18'd0, opcode, f3, f7, rd}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        chk("illegal_count", 32'(ill_cnt), 32'd4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
